// File: rtl/otp_pkg.sv
// Shared types and constants for the one-time-pad XOR cipher stage.
package otp_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W      = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED  = 3'd1,
    WARM  = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4
  } state_e;
endpackage

// File: rtl/otp_out_stage.sv
// One-entry valid/ready output register; reloads on the same edge it drains.
module otp_out_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         last,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic         ready_up
);
  logic         valid_q;
  logic [W-1:0] data_q;
  logic         last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= data;
      last_q  <= last;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign ready_up  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
endmodule

// File: rtl/otp_xor_cipher.sv
// Seeds the PRNG, discards WARMUP keystream bytes, then XORs one key byte per consumed byte.
// Optional byte counter outputs (byte_cnt, cnt_sat) exist only with OTP_BYTE_COUNT_EN defined.
module otp_xor_cipher
  import otp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int WARMUP = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              prng_load,
  output logic [DATA_W-1:0] prng_seed,
  output logic              key_en,
  input  logic [DATA_W-1:0] key_in,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy
`ifdef OTP_BYTE_COUNT_EN
  ,
  output logic [15:0]       byte_cnt,
  output logic              cnt_sat
`endif
);
  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] seed_q;
  logic              ready_up;
  logic              xfer;

  assign in_ready  = (state_q == RUN) && ready_up;
  assign xfer      = in_valid && in_ready;
  // Keystream only moves during warm-up or on a consumed byte, keeping both ends aligned.
  assign key_en    = (state_q == WARM) || xfer;
  assign prng_load = (state_q == SEED);
  assign prng_seed = seed_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seed_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          seed_q  <= seed;
          state_q <= SEED;
        end
        SEED: begin
          cnt_q   <= CNT_W'(WARMUP);
          state_q <= (WARMUP == 0) ? RUN : WARM;
        end
        WARM: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= RUN;
        end
        RUN:     if (xfer && in_last) state_q <= DRAIN;
        DRAIN:   if (!out_valid || out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  otp_out_stage #(.W(DATA_W)) u_out (
    .clk       (clk),
    .reset     (reset),
    .load      (xfer),
    .data      (in_data ^ key_in),
    .last      (in_last),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .ready_up  (ready_up)
  );

`ifdef OTP_BYTE_COUNT_EN
  logic [15:0] bcnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     bcnt_q <= '0;
    else if (state_q == SEED)       bcnt_q <= '0;
    else if (xfer && !(&bcnt_q))    bcnt_q <= bcnt_q + 16'd1;
  end

  assign byte_cnt = bcnt_q;
  assign cnt_sat  = &bcnt_q;
`endif
endmodule

// File: tb/tb_otp_xor_cipher.sv
// Directed bench: WARMUP=0 instance with a driven key, plus a WARMUP=4 encrypt/decrypt pair on LFSR models.
module tb_otp_xor_cipher;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] nxt(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // instance 0: WARMUP=0, key driven directly
  logic rst0 = 1'b0, start0 = 1'b0, iv0 = 1'b0, il0 = 1'b0, or0 = 1'b0;
  logic [7:0] seed0 = '0, key0 = '0, id0 = '0;
  logic pl0, ke0, ir0, ov0, ol0, busy0;
  logic [7:0] ps0, od0;

  // instances 1 (encrypt) and 2 (decrypt), WARMUP=4, chained
  logic rst12 = 1'b0, start12 = 1'b0, iv1 = 1'b0, il1 = 1'b0, gate = 1'b0;
  logic [7:0] seed12 = '0, id1 = '0;
  logic pl1, ke1, ir1, ov1, ol1, busy1, or1;
  logic pl2, ke2, ir2, ov2, ol2, busy2, iv2;
  logic [7:0] ps1, od1, ps2, od2;
  logic [7:0] lf1 = '0, lf2 = '0;

  assign or1 = gate & ir2;
  assign iv2 = ov1 & gate;

`ifdef OTP_BYTE_COUNT_EN
  logic [15:0] bc0, bc1, bc2;
  logic cs0, cs1, cs2;
`endif

  otp_xor_cipher #(.DATA_W(8), .WARMUP(0)) dut0 (
    .clk(clk), .reset(rst0), .start(start0), .seed(seed0),
    .prng_load(pl0), .prng_seed(ps0), .key_en(ke0), .key_in(key0),
    .in_valid(iv0), .in_data(id0), .in_last(il0), .in_ready(ir0),
    .out_valid(ov0), .out_data(od0), .out_last(ol0), .out_ready(or0), .busy(busy0)
`ifdef OTP_BYTE_COUNT_EN
    , .byte_cnt(bc0), .cnt_sat(cs0)
`endif
  );

  otp_xor_cipher #(.DATA_W(8), .WARMUP(4)) dut1 (
    .clk(clk), .reset(rst12), .start(start12), .seed(seed12),
    .prng_load(pl1), .prng_seed(ps1), .key_en(ke1), .key_in(lf1),
    .in_valid(iv1), .in_data(id1), .in_last(il1), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_last(ol1), .out_ready(or1), .busy(busy1)
`ifdef OTP_BYTE_COUNT_EN
    , .byte_cnt(bc1), .cnt_sat(cs1)
`endif
  );

  otp_xor_cipher #(.DATA_W(8), .WARMUP(4)) dut2 (
    .clk(clk), .reset(rst12), .start(start12), .seed(seed12),
    .prng_load(pl2), .prng_seed(ps2), .key_en(ke2), .key_in(lf2),
    .in_valid(iv2), .in_data(od1), .in_last(ol1), .in_ready(ir2),
    .out_valid(ov2), .out_data(od2), .out_last(ol2), .out_ready(1'b1), .busy(busy2)
`ifdef OTP_BYTE_COUNT_EN
    , .byte_cnt(bc2), .cnt_sat(cs2)
`endif
  );

  // bench PRNG models
  always @(posedge clk) begin
    if (pl1) lf1 <= ps1; else if (ke1) lf1 <= nxt(lf1);
    if (pl2) lf2 <= ps2; else if (ke2) lf2 <= nxt(lf2);
  end

  logic [8:0] q1[$], q2[$];
  logic ke_cnt_en = 1'b0;
  int run_ke1 = 0;
  always @(negedge clk) begin
    if (ov1 && or1) q1.push_back({ol1, od1});
    if (ov2) q2.push_back({ol2, od2});
    if (ke_cnt_en && ke1) run_ke1++;
  end

  typedef struct {
    logic [7:0] key;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;
  vec_t vt[5];

  task automatic one_byte(input vec_t v, input int n);
    seed0 = 8'(n); start0 = 1'b1; step(); start0 = 1'b0;
    step();
    key0 = v.key; id0 = v.din; il0 = 1'b1; iv0 = 1'b1; or0 = 1'b1;
    #1 chk($sformatf("vec%0d key_en", n), ke0, 1);
    step(); iv0 = 1'b0; il0 = 1'b0;
    chk($sformatf("vec%0d out_data", n), od0, v.exp);
    chk($sformatf("vec%0d out_valid", n), ov0, 1);
    chk($sformatf("vec%0d out_last", n), ol0, 1);
    step();
    chk($sformatf("vec%0d idle", n), busy0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pt[3], ct[3], k;
    int warm, guard, idx;
    logic acc;

    vt[0] = '{8'hA5, 8'h3C, 8'h99};
    vt[1] = '{8'h12, 8'h34, 8'h26};
    vt[2] = '{8'h5A, 8'h5A, 8'h00};
    vt[3] = '{8'h80, 8'h01, 8'h81};
    vt[4] = '{8'hFF, 8'h0F, 8'hF0};
    pt[0] = 8'h48; pt[1] = 8'h69; pt[2] = 8'h21;
    seed12 = 8'h5B;
    k = seed12;
    repeat (4) k = nxt(k);
    for (int i = 0; i < 3; i++) begin ct[i] = pt[i] ^ k; k = nxt(k); end

    // 1: reset held with start asserted
    start0 = 1'b1;
    repeat (3) step();
    chk("rst prng_load", pl0, 0);
    chk("rst prng_seed", ps0, 0);
    chk("rst key_en", ke0, 0);
    chk("rst in_ready", ir0, 0);
    chk("rst out_valid", ov0, 0);
    chk("rst out_data", od0, 0);
    chk("rst out_last", ol0, 0);
    chk("rst busy", busy0, 0);
    rst0 = 1'b1; rst12 = 1'b1; start0 = 1'b0; or0 = 1'b1;
    step();
    chk("idle in_ready", ir0, 0);
    seed0 = 8'd22; start0 = 1'b1; step(); start0 = 1'b0;
    chk("seed prng_load", pl0, 1);
    chk("seed prng_seed", ps0, 8'd22);
    chk("seed key_en", ke0, 0);
    chk("seed busy", busy0, 1);
    step();
    chk("run prng_load", pl0, 0);
    chk("run in_ready", ir0, 1);
    chk("run idle key_en", ke0, 0);

    // 2: single byte
    key0 = 8'hA5; id0 = 8'h3C; il0 = 1'b1; iv0 = 1'b1;
    #1 chk("t2 key_en", ke0, 1);
    step(); iv0 = 1'b0; il0 = 1'b0;
    chk("t2 out_data", od0, 8'h99);
    chk("t2 out_last", ol0, 1);
    chk("t2 out_valid", ov0, 1);
    chk("t2 key_en once", ke0, 0);
    step();
    chk("t2 out_valid clr", ov0, 0);
    chk("t2 idle", busy0, 0);

    for (int i = 0; i < 5; i++) one_byte(vt[i], i + 1);

    // 3: warm-up count
    start12 = 1'b1; step(); start12 = 1'b0;
    chk("t3 prng_load", pl1, 1);
    chk("t3 prng_seed", ps1, 8'h5B);
    step();
    warm = 0; guard = 0;
    while (!ir1 && guard < 20) begin
      if (ke1) warm++;
      step(); guard++;
    end
    chk("t3 reached run", ir1, 1);
    chk("t3 warm pulses", warm, 4);

    // 4: backpressure on the encryptor, decryptor chained behind it
    ke_cnt_en = 1'b1;
    iv1 = 1'b1; id1 = pt[0]; il1 = 1'b0;
    #1 chk("t4 first in_ready", ir1, 1);
    step();
    id1 = pt[1];
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t4 stall%0d in_ready", i), ir1, 0);
      chk($sformatf("t4 stall%0d key_en", i), ke1, 0);
      chk($sformatf("t4 stall%0d out_valid", i), ov1, 1);
      chk($sformatf("t4 stall%0d out_data", i), od1, ct[0]);
      step();
    end
    gate = 1'b1; idx = 1; guard = 0;
    while (idx < 3 && guard < 30) begin
      #1 acc = iv1 && ir1;
      step(); guard++;
      if (acc) idx++;
      iv1 = (idx < 3);
      id1 = (idx < 3) ? pt[idx] : 8'h00;
      il1 = (idx == 2);
    end
    iv1 = 1'b0; il1 = 1'b0;
    guard = 0;
    while ((q1.size() < 3 || q2.size() < 3) && guard < 30) begin step(); guard++; end
    ke_cnt_en = 1'b0;
    chk("t4 enc count", q1.size(), 3);
    chk("t5 dec count", q2.size(), 3);
    chk("t4 run key_en", run_ke1, 3);
    for (int i = 0; i < 3; i++) begin
      if (i < q1.size()) chk($sformatf("t4 ct%0d", i), q1[i], {(i == 2), ct[i]});
      if (i < q2.size()) chk($sformatf("t5 pt%0d", i), q2[i], {(i == 2), pt[i]});
    end
    step(); step();
    chk("t4 enc idle", busy1, 0);
    chk("t5 dec idle", busy2, 0);
`ifdef OTP_BYTE_COUNT_EN
    chk("t6 byte_cnt", bc1, 16'd3);
    chk("t6 cnt_sat", cs1, 0);
`endif

    // 6: start ignored in RUN, then reset mid-RUN
    seed0 = 8'h77; start0 = 1'b1; step(); start0 = 1'b0; step();
    key0 = 8'h0F; id0 = 8'h55; il0 = 1'b0; iv0 = 1'b1; or0 = 1'b0;
    step(); iv0 = 1'b0;
    chk("t6 out_valid", ov0, 1);
    chk("t6 out_data", od0, 8'h5A);
    start0 = 1'b1; step(); start0 = 1'b0;
    chk("t6 start ignored load", pl0, 0);
    chk("t6 start ignored busy", busy0, 1);
    chk("t6 hold data", od0, 8'h5A);
    rst0 = 1'b0;
    #1;
    chk("t6 rst out_valid", ov0, 0);
    chk("t6 rst busy", busy0, 0);
    chk("t6 rst in_ready", ir0, 0);
    step(); rst0 = 1'b1; step();
    chk("t6 after rst idle", busy0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/otp_xor_cipher.md
Name: otp_xor_cipher

Overview:
- Downstream consumer of the prng stage in the one-time-pad datapath.
- Seeds the PRNG, discards WARMUP keystream bytes, then XORs each plaintext byte with one keystream byte to produce ciphertext. Decryption is the same operation on ciphertext.
- Steps the keystream only when a byte is consumed, so encryptor and decryptor stay byte-aligned regardless of stalls.
- Valid/ready handshake on the plaintext input and the ciphertext output.

Parameters:
- DATA_W, 8, width of seed, keystream, plaintext and ciphertext bytes.
- WARMUP, 4, number of keystream steps discarded after seeding; 0 is legal; max 255.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a message; sampled only in IDLE.
- seed  in  DATA_W  message key seed; captured when start is accepted.
- prng_load  out  1  load strobe to the prng stage.
- prng_seed  out  DATA_W  seed value driven to the prng stage.
- key_en  out  1  keystream step enable; the prng advances on edges where key_en=1.
- key_in  in  DATA_W  current keystream byte from the prng.
- in_valid  in  1  plaintext byte valid.
- in_data  in  DATA_W  plaintext byte.
- in_last  in  1  marks the final byte of the message.
- in_ready  out  1  block can accept a plaintext byte.
- out_valid  out  1  ciphertext byte valid.
- out_data  out  DATA_W  ciphertext byte.
- out_last  out  1  final ciphertext byte.
- out_ready  in  1  downstream accepts the ciphertext byte.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - prng_load, prng_seed, key_en, in_ready, out_valid, out_data, out_last, busy and the warm-up counter all go to 0.
  - Reset mid-message drops any in-flight byte with no ciphertext emitted.
- State machine: IDLE -> SEED -> WARM -> RUN -> DRAIN -> IDLE.
- IDLE:
  - in_ready=0.
  - start=1 captures seed into seed_q and moves to SEED.
  - start is ignored in every other state.
- SEED:
  - Lasts exactly 1 cycle.
  - prng_load=1 and prng_seed=seed_q; key_en=0.
  - Next state is WARM with cnt=WARMUP; if WARMUP=0, next state is RUN.
- WARM:
  - key_en=1 every cycle and cnt decrements.
  - When cnt=1, the next state is RUN.
  - Exactly WARMUP keystream steps are discarded.
- RUN:
  - in_ready = !out_valid || out_ready (1-entry output register, full-throughput pass-through).
  - Input transfer (in_valid && in_ready):
    - out_data <= in_data ^ key_in, out_last <= in_last, out_valid <= 1.
    - key_en=1 combinationally in the same cycle.
  - key_en=0 in RUN whenever there is no transfer, so the keystream never advances without a consumed byte.
  - Output transfer (out_valid && out_ready) with no simultaneous input transfer: out_valid <= 0.
  - Simultaneous input and output transfer: the register reloads and out_valid stays 1.
  - A transfer with in_last=1 moves to DRAIN.
- DRAIN:
  - in_ready=0 and key_en=0.
  - When out_valid && out_ready, clear out_valid and move to IDLE.
  - If out_valid is already 0, move to IDLE next cycle.
- Latency: 1 cycle from input transfer to out_valid.
- Output hold: out_data and out_last hold stable while out_valid && !out_ready.
- Arithmetic: bitwise XOR only; no width change.

Optional Feature:
- Macro: OTP_BYTE_COUNT_EN.
- Defined:
  - Adds output byte_cnt [15:0], which counts input transfers in the current message.
  - byte_cnt clears on SEED and saturates at 16'hFFFF.
  - Adds output cnt_sat, which is high while byte_cnt is saturated.
- Undefined: neither port nor the counter logic exists.

Decomposition:
- Package otp_pkg holds:
  - DATA_W default constant.
  - State enum {IDLE, SEED, WARM, RUN, DRAIN} as a 3-bit typedef.
  - WARMUP counter width constant (8).
- Sub-module otp_out_stage: the 1-entry valid/ready output register, with ports load, data, last, out_*, ready_up.
  - The state machine and XOR remain in the top.

Test Plan:
1. Reset and seed, WARMUP=0, bench PRNG model:
   - Hold reset=0 with start=1 -> all outputs 0, busy=0.
   - Release reset, pulse start with seed=8'd22 -> prng_load=1 with prng_seed=8'd22 for exactly 1 cycle, then in_ready=1 while out_ready=1.
2. Single byte:
   - key_in=8'hA5, in_data=8'h3C, in_last=1 -> next cycle out_data=8'h99, out_last=1, out_valid=1.
   - key_en high for exactly 1 cycle.
   - Return to IDLE after out_ready.
3. Warm-up count, WARMUP=4:
   - Count key_en pulses between prng_load and the first in_ready -> exactly 4.
4. Backpressure:
   - Stream 3 bytes with out_ready=0 for 5 cycles -> out_data holds its value, in_ready=0, key_en=0 throughout.
   - Release -> bytes emerge in order, and total key_en pulses in RUN equal 3.
5. Round trip:
   - Feed ciphertext from test 4 into a second instance with the same seed -> recovered plaintext equals the original bytes.
6. Corner cases:
   - Assert reset mid-RUN with out_valid=1 -> out_valid=0 immediately and state IDLE.
   - Assert start in RUN -> ignored.
   - With OTP_BYTE_COUNT_EN defined, 3-byte message -> byte_cnt=3.
